// File: rtl/mpc_div_pkg.sv
// Shared constants and types for the MPC sequential signed/unsigned divider.
// Holds the operand widths, the FSM state encoding, the saturation limits of
// the signed quotient and the width of the bit counter.
package mpc_div_pkg;

  localparam int unsigned AW   = 29;         // dividend width (signed)
  localparam int unsigned BW   = 7;          // divisor width (unsigned)
  localparam int unsigned QW   = 21;         // quotient width (signed, saturating)
  localparam int unsigned RW   = BW + 1;     // remainder width (signed)
  localparam int unsigned CntW = $clog2(AW);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } state_e;

  localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};  //  2^(QW-1)-1
  localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};  // -2^(QW-1)

  // Largest quotient magnitudes that still fit, for each sign of the result.
  localparam logic [AW-1:0] MagPosMax = AW'(QMAX);
  localparam logic [AW-1:0] MagNegMax = AW'(QMIN);

endpackage

// File: rtl/mpc_div_step.sv
// One combinational restoring-division step.
//   rem      : current partial remainder (always < b between steps)
//   bit_in   : next dividend magnitude bit, MSB first
//   b        : unsigned divisor
//   rem_next : partial remainder after the conditional subtract
//   q_bit    : quotient bit produced by this step
module mpc_div_step
  import mpc_div_pkg::*;
(
  input  logic [RW-1:0] rem,
  input  logic          bit_in,
  input  logic [BW-1:0] b,
  output logic [RW-1:0] rem_next,
  output logic          q_bit
);

  logic [RW-1:0] partial;

  always_comb begin
    partial  = {rem[BW-1:0], bit_in};
    // A set top bit of rem means the shifted value certainly exceeds b.
    q_bit    = rem[BW] | (partial >= {1'b0, b});
    rem_next = q_bit ? (partial - {1'b0, b}) : partial;
  end

endmodule

// File: rtl/mpc_div_29s_7ns_21_seq.sv
// Sequential signed-by-unsigned divider: a (29-bit signed) / b (7-bit
// unsigned) -> q (21-bit signed, truncated toward zero, saturated) and
// r (8-bit signed, sign of a). One quotient bit per ce-cycle.
// Ports:
//   clk, rst (sync, active-low), ce (clock enable, freezes everything)
//   start, a, b      : request and operands, taken in IDLE with ce=1
//   q, r, dbz, ovf   : registered result, held until the next done
//   busy             : high from the accepting edge until done falls
//   done             : one-ce-cycle result pulse
module mpc_div_29s_7ns_21_seq
  import mpc_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          start,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [QW-1:0] q,
  output logic [RW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic          ovf
);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  // Holds |a| at accept; shifts left each step, quotient bits enter at the LSB,
  // so after AW steps it holds the magnitude quotient.
  logic [AW-1:0]   acc_q;
  logic [RW-1:0]   rem_q;
  logic [BW-1:0]   b_q;
  logic            neg_q;

  logic [AW-1:0]   a_mag;
  logic [RW-1:0]   step_rem;
  logic            step_qbit;
  logic [QW-1:0]   fix_q;
  logic [RW-1:0]   fix_r;
  logic            fix_ovf;

  mpc_div_step u_step (
    .rem      (rem_q),
    .bit_in   (acc_q[AW-1]),
    .b        (b_q),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  // |-2^(AW-1)| wraps to 2^(AW-1), which is still correct as an unsigned value.
  assign a_mag = a[AW-1] ? (~a + 1'b1) : a;

  // Sign restoration and saturation of the magnitude result.
  always_comb begin
    fix_ovf = 1'b0;
    fix_r   = neg_q ? (~rem_q + 1'b1) : rem_q;
    if (neg_q) begin
      if (acc_q > MagNegMax) begin
        fix_q   = QMIN;
        fix_ovf = 1'b1;
      end else begin
        fix_q = ~acc_q[QW-1:0] + 1'b1;
      end
    end else begin
      if (acc_q > MagPosMax) begin
        fix_q   = QMAX;
        fix_ovf = 1'b1;
      end else begin
        fix_q = acc_q[QW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      ovf     <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            acc_q   <= a_mag;
            b_q     <= b;
            neg_q   <= a[AW-1];
            rem_q   <= '0;
            cnt_q   <= CntW'(AW - 1);
            busy    <= 1'b1;
            state_q <= (b == '0) ? StFix : StCalc;
          end else begin
            busy <= 1'b0;
          end
        end
        StCalc: begin
          rem_q <= step_rem;
          acc_q <= {acc_q[AW-2:0], step_qbit};
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          done    <= 1'b1;
          state_q <= StIdle;
          if (b_q == '0) begin
            q   <= neg_q ? QMIN : QMAX;
            r   <= '0;
            dbz <= 1'b1;
            ovf <= 1'b0;
          end else begin
            q   <= fix_q;
            r   <= fix_r;
            dbz <= 1'b0;
            ovf <= fix_ovf;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_div_29s_7ns_21_seq.sv
module tb_mpc_div_29s_7ns_21_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic [28:0] a = '0;
  logic [6:0]  b = '0;
  logic [20:0] q;
  logic [7:0]  r;
  logic        busy, done, dbz, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mpc_div_29s_7ns_21_seq dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  // Reference: plain truncating integer division, then saturation.
  function automatic void model(input logic signed [28:0] ia, input logic [6:0] ib,
                                output logic [20:0] mq, output logic [7:0] mr,
                                output logic mdbz, output logic movf);
    longint aa, tq, tr;
    aa = ia;
    if (ib == 7'd0) begin
      mdbz = 1'b1;
      movf = 1'b0;
      mr   = 8'd0;
      mq   = (aa < 0) ? 21'h100000 : 21'h0FFFFF;
    end else begin
      mdbz = 1'b0;
      tq   = aa / longint'(ib);
      tr   = aa % longint'(ib);
      mr   = tr[7:0];
      if (tq > 64'sd1048575) begin
        mq = 21'h0FFFFF;
        movf = 1'b1;
      end else if (tq < -64'sd1048576) begin
        mq = 21'h100000;
        movf = 1'b1;
      end else begin
        mq = tq[20:0];
        movf = 1'b0;
      end
    end
  endfunction

  // Issue one request at the current negedge and wait (bounded) for done.
  task automatic do_op(input logic [28:0] ia, input logic [6:0] ib,
                       output int lat, output int bcnt);
    start = 1'b1;
    a = ia;
    b = ib;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ce = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({q, r, busy, done, dbz, ovf} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
               q, r, busy, done, dbz, ovf);
    end
    rst = 1'b1;
    ce = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic signed [28:0] da [11] = '{29'sd1000, -29'sd1000, 29'sd268435455, -29'sd268435456,
                                    -29'sd1048576, 29'sd5, -29'sd5, 29'sd7340025,
                                    -29'sd7340032, 29'sd0, -29'sd1};
    logic [6:0] db [11] = '{7'd7, 7'd7, 7'd1, 7'd1, 7'd1, 7'd0, 7'd0, 7'd7, 7'd7, 7'd5, 7'd127};
    logic [20:0] eq;
    logic [7:0]  er;
    logic        edbz, eovf;
    int          lat, bcnt, elat;
    for (int i = 0; i < 11; i++) begin
      do_op(da[i], db[i], lat, bcnt);
      model(da[i], db[i], eq, er, edbz, eovf);
      elat = (db[i] == 7'd0) ? 1 : 30;
      n_cmp++;
      if (lat != elat) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, elat);
      end
      n_cmp++;
      if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
        n_bad++;
        $display("FAIL directed_result[%0d] a=%0d b=%0d: got q=%0d r=%0d dbz=%b ovf=%b, want q=%0d r=%0d dbz=%b ovf=%b",
                 i, da[i], db[i], $signed(q), $signed(r), dbz, ovf,
                 $signed(eq), $signed(er), edbz, eovf);
      end
      if (i == 0) begin
        n_cmp++;
        if (bcnt != 30) begin
          n_bad++;
          $display("FAIL busy_cycles: got %0d want 30", bcnt);
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_bad++;
        $display("FAIL done_pulse[%0d]: got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_random();
    logic [28:0] ra;
    logic [6:0]  rb;
    logic [20:0] eq;
    logic [7:0]  er;
    logic        edbz, eovf;
    int          lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? 29'($urandom)
                                       : 29'($urandom_range(0, 16777215) - 32'd8388608);
      rb = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      do_op(ra, rb, lat, bcnt);
      model(ra, rb, eq, er, edbz, eovf);
      n_cmp++;
      if (lat != ((rb == 7'd0) ? 1 : 30) || {q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
        n_bad++;
        $display("FAIL random[%0d] a=%0d b=%0d: got lat=%0d q=%0d r=%0d dbz=%b ovf=%b, want q=%0d r=%0d dbz=%b ovf=%b",
                 i, $signed(ra), rb, lat, $signed(q), $signed(r), dbz, ovf,
                 $signed(eq), $signed(er), edbz, eovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat, extra;
    start = 1'b1;
    a = 29'd100;
    b = 7'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == 9) begin
        start = 1'b1;
        a = 29'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_cmp++;
    if (lat != 30 || q !== 21'd33 || r !== 8'd1) begin
      n_bad++;
      $display("FAIL busy_ignore: got lat=%0d q=%0d r=%0d, want lat=30 q=33 r=1",
               lat, $signed(q), $signed(r));
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL busy_not_queued: got %0d extra done cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] eq;
    logic [7:0]  er;
    logic        edbz, eovf;
    int          lat1, lat2, bcnt;
    do_op(29'd123456, 7'd100, lat1, bcnt);
    model(29'sd123456, 7'd100, eq, er, edbz, eovf);
    n_cmp++;
    if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
      n_bad++;
      $display("FAIL b2b_first: got q=%0d r=%0d, want q=%0d r=%0d",
               $signed(q), $signed(r), $signed(eq), $signed(er));
    end
    // Start issued on the done cycle itself.
    do_op(-29'sd4567, 7'd13, lat2, bcnt);
    model(-29'sd4567, 7'd13, eq, er, edbz, eovf);
    n_cmp++;
    if (lat2 + 1 != 31) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d cycles between dones, want 31", lat2 + 1);
    end
    n_cmp++;
    if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
      n_bad++;
      $display("FAIL b2b_second: got q=%0d r=%0d, want q=%0d r=%0d",
               $signed(q), $signed(r), $signed(eq), $signed(er));
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [20:0] eq;
    logic [7:0]  er;
    logic        edbz, eovf;
    int          lat;
    start = 1'b1;
    a = 29'd123456;
    b = 7'd9;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      ce = !(lat >= 10 && lat < 15);
      @(negedge clk);
      lat++;
    end
    ce = 1'b1;
    model(29'sd123456, 7'd9, eq, er, edbz, eovf);
    n_cmp++;
    if (lat != 35 || {q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
      n_bad++;
      $display("FAIL stall: got lat=%0d q=%0d r=%0d, want lat=35 q=%0d r=%0d",
               lat, $signed(q), $signed(r), $signed(eq), $signed(er));
    end
    ce = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || q !== eq) begin
      n_bad++;
      $display("FAIL stall_hold_done: got done=%b busy=%b q=%0d, want 1 1 %0d",
               done, busy, $signed(q), $signed(eq));
    end
    ce = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL stall_release: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen, lat, bcnt;
    start = 1'b1;
    a = -29'sd999;
    b = 7'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++;
    if ({q, r, busy, done, dbz, ovf} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
               q, r, busy, done, dbz, ovf);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: got %0d done cycles, want 0", seen);
    end
    do_op(29'd50, 7'd7, lat, bcnt);
    n_cmp++;
    if (lat != 30 || q !== 21'd7 || r !== 8'd1) begin
      n_bad++;
      $display("FAIL reset_recover: got lat=%0d q=%0d r=%0d, want lat=30 q=7 r=1",
               lat, $signed(q), $signed(r));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mpc_div_29s_7ns_21_seq.md
Name: mpc_div_29s_7ns_21_seq

Overview:
Sequential signed-by-unsigned integer divider, the inverse operation of the 21s x 7ns -> 29-bit DSP multiplier in the MPC datapath. It divides a signed 29-bit product-domain value by an unsigned 7-bit scale factor to return a signed 21-bit quotient and a remainder. It computes one quotient bit per cycle with a restoring shift-subtract loop and uses a start/done handshake. It sits beside the multiplier in the implicit-MPC solver, where fixed-point rescaling needs exact truncating division.

Parameters:
AW, 29, dividend width (signed)
BW, 7, divisor width (unsigned)
QW, 21, quotient width (signed, saturating)
RW, BW+1, remainder width (signed)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low
ce  in  1  clock enable; when low, all registers hold
start  in  1  request; accepted only in IDLE with ce=1
a  in  AW  signed dividend, sampled on the accepting edge
b  in  BW  unsigned divisor, sampled on the accepting edge
q  out  QW  signed quotient, truncated toward zero, saturated
r  out  RW  signed remainder; sign follows a; |r| < b
busy  out  1  high from the accepting edge until done falls
done  out  1  single-cycle pulse; q/r/flags valid while high and held until the next done
dbz  out  1  divide-by-zero flag for the current result
ovf  out  1  quotient saturated

Behaviour:
- Reset (rst=0 at an edge, independent of ce): state=IDLE; q=0, r=0, busy=0, done=0, dbz=0, ovf=0; any operation in flight is discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE + start + ce (edge E0):
  - latch |a| as an AW-bit unsigned magnitude (|-2^28| = 2^28 fits) and b;
  - latch neg = a[AW-1]; clear the partial remainder; cnt = AW-1; busy=1.
  - Next state: FIX if b==0, else CALC.
- CALC, one step per ce edge:
  - partial remainder = {rem, next magnitude MSB};
  - if the partial remainder is >= b, subtract b and shift in quotient bit 1, else shift in 0.
  - After the step with cnt==0, go to FIX; otherwise decrement cnt.
  - Exactly AW CALC edges (E1..E29).
- FIX (edge E30, or E1 when b==0):
  - Magnitude result: q = mq, r = mrem.
  - If neg: q = -mq, r = -mrem.
  - Positive saturation: if !neg and mq > 2^(QW-1)-1, then q = 2^(QW-1)-1 and ovf=1.
  - Negative saturation: if neg and mq > 2^(QW-1), then q = -2^(QW-1) and ovf=1. mq == 2^(QW-1) with neg gives exactly -2^(QW-1) with ovf=0.
  - b==0: q = 2^(QW-1)-1 if !neg else -2^(QW-1); r=0; dbz=1; ovf=0.
  - done=1; state becomes IDLE.
- done is a pulse: it falls on the next ce edge. busy falls on the same edge.
- Latency: done is high in the cycle after edge E30, i.e. 30 ce-cycles after start is accepted. For b==0, done is high after E1.
- start while busy is ignored and not queued.
- start on the edge where done is high is accepted: back-to-back throughput is one result per 31 ce-cycles.
- ce=0 freezes FSM, counter, datapath, and all outputs, including a high done, which stays high until the next ce edge.
- Width rule: the internal remainder register is BW+1 bits, so the compare and subtract never lose the carry. The magnitude quotient register is AW bits before saturation.

Decomposition:
- Shared package mpc_div_pkg holds:
  - state encoding constants (IDLE=0, CALC=1, FIX=2);
  - QMAX = 2^(QW-1)-1 and QMIN = -2^(QW-1);
  - the counter width as clog2(AW).
- One sub-module is natural: mpc_div_step, a combinational single restoring step. It takes (rem, bit_in, b) and produces (rem_next, q_bit). The top module holds the FSM, counter, sign handling, and saturation.

Test Plan:
- a=1000, b=7, start for 1 cycle -> done after 30 cycles; q=142, r=6, ovf=0, dbz=0; busy high for 30 cycles.
- a=-1000, b=7 -> q=-142, r=-6.
- Overflow cases:
  - a=268435455, b=1 -> q=1048575, ovf=1.
  - a=-268435456, b=1 -> q=-1048576, ovf=1.
  - a=-1048576, b=1 -> q=-1048576, ovf=0.
- Divide by zero:
  - a=5, b=0 -> done 1 cycle after accept; q=1048575, r=0, dbz=1.
  - a=-5, b=0 -> q=-1048576, dbz=1.
- Busy and back-to-back handling:
  - a=100, b=3; second start at cycle 10 with a=7 -> second start ignored; q=33, r=1.
  - Start re-asserted on the done cycle -> accepted; next done exactly 31 cycles after the first.
- Stall and reset:
  - ce low for 5 cycles mid-CALC -> done delayed by exactly 5 cycles, same result.
  - rst=0 at cycle 15 of an operation -> busy=0, done never pulses, all outputs 0.
